// File: rtl/core_pkg.sv
// Shared constants and types for the core front end: default widths, reset/trap
// vectors and the next-PC source select.
package core_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JALR,
    SEL_PEND,
    SEL_TRAP
  } pc_sel_e;

  // Only 32-bit-only cores can see a misaligned target; with C bit 0 is forced low.
  function automatic logic target_misaligned(input logic bit1, input int c_ext);
    return (c_ext == 0) && bit1;
  endfunction

endpackage

// File: rtl/pc_target_gen.sv
// Combinational next-PC candidates: sequential step, PC-relative branch/JAL,
// JALR, the selected live redirect target and its alignment status.
module pc_target_gen
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int          C_EXT = 0
) (
  input  logic [XLEN-1:0] pc,
  input  logic            is_compressed,
  input  logic            branch_taken,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] seq,
  output logic [XLEN-1:0] br,
  output logic [XLEN-1:0] jr,
  output logic [XLEN-1:0] tgt,
  output logic            misaligned
);

  logic [XLEN-1:0] jr_sum;
  logic            half_step;

  assign half_step = (C_EXT != 0) && is_compressed;
  assign seq       = pc + (half_step ? XLEN'(2) : XLEN'(4));
  assign br        = pc + imm_ext;
  assign jr_sum    = rs1 + imm_ext;
  assign jr        = {jr_sum[XLEN-1:1], 1'b0};

  // JALR takes precedence when decode raises both redirect requests.
  always_comb begin
    tgt = br;
    if (jalr) begin
      tgt = jr;
    end else if (branch_taken) begin
      tgt = br;
    end
  end

  assign misaligned = target_misaligned(tgt[1], C_EXT);

endmodule

// File: rtl/pc_unit.sv
// Program-counter register with stall, a one-entry pending-redirect buffer,
// optional compressed stepping and misaligned-target trapping.
module pc_unit
  import core_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEFAULT),
  parameter int              C_EXT        = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            is_compressed,
  input  logic            branch_taken,
  input  logic            jalr,
  input  logic [XLEN-1:0] ImmExt,
  input  logic [XLEN-1:0] RS1,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic [XLEN-1:0] PCTarget,
  output logic            misalign_exc,
  output logic [XLEN-1:0] bad_addr,
  output logic            redirect_pending
);

  logic [XLEN-1:0] seq, br, jr, tgt;
  logic            tgt_misaligned;
  logic            redir;
  logic [XLEN-1:0] pend_target;
  logic            pend_misaligned;
  logic [XLEN-1:0] app_target;
  logic [XLEN-1:0] next_pc;
  pc_sel_e         sel;

  pc_target_gen #(
    .XLEN (XLEN),
    .C_EXT(C_EXT)
  ) u_target_gen (
    .pc           (PC),
    .is_compressed(is_compressed),
    .branch_taken (branch_taken),
    .jalr         (jalr),
    .imm_ext      (ImmExt),
    .rs1          (RS1),
    .seq          (seq),
    .br           (br),
    .jr           (jr),
    .tgt          (tgt),
    .misaligned   (tgt_misaligned)
  );

  assign redir           = jalr | branch_taken;
  assign PCPlus4         = seq;
  assign PCTarget        = br;
  assign pend_misaligned = target_misaligned(pend_target[1], C_EXT);
  assign app_target      = redir ? tgt : pend_target;

  // Alignment is judged when a target is applied, so a buffered target is checked on release.
  always_comb begin
    sel = SEL_SEQ;
    if (!stall) begin
      if (redir) begin
        if (tgt_misaligned)   sel = SEL_TRAP;
        else if (jalr)        sel = SEL_JALR;
        else                  sel = SEL_BR;
      end else if (redirect_pending) begin
        if (pend_misaligned)  sel = SEL_TRAP;
        else                  sel = SEL_PEND;
      end
    end
  end

  always_comb begin
    next_pc = seq;
    case (sel)
      SEL_BR:   next_pc = br;
      SEL_JALR: next_pc = jr;
      SEL_PEND: next_pc = pend_target;
      SEL_TRAP: next_pc = TRAP_VECTOR;
      default:  next_pc = seq;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC               <= RESET_VECTOR;
      misalign_exc     <= 1'b0;
      bad_addr         <= '0;
      redirect_pending <= 1'b0;
      pend_target      <= '0;
    end else begin
      misalign_exc <= 1'b0;
      if (stall) begin
        if (redir) begin
          pend_target      <= tgt;
          redirect_pending <= 1'b1;
        end
      end else begin
        PC               <= next_pc;
        redirect_pending <= 1'b0;
        if (sel == SEL_TRAP) begin
          misalign_exc <= 1'b1;
          bad_addr     <= app_target;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: one instance without and one with compressed
// support, driven by the same inputs and compared against a behavioural model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, is_compressed, branch_taken, jalr;
  logic [31:0] imm, rs1;

  logic [1:0][31:0] pc_o, plus4_o, target_o, bad_o;
  logic [1:0]       exc_o, pend_o;

  logic [1:0][31:0] m_pc, m_pend, m_bad;
  logic [1:0]       m_pv, m_exc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_unit #(.C_EXT(0)) u_dut0 (
    .clk(clk), .rst(rst), .stall(stall), .is_compressed(is_compressed),
    .branch_taken(branch_taken), .jalr(jalr), .ImmExt(imm), .RS1(rs1),
    .PC(pc_o[0]), .PCPlus4(plus4_o[0]), .PCTarget(target_o[0]),
    .misalign_exc(exc_o[0]), .bad_addr(bad_o[0]), .redirect_pending(pend_o[0])
  );

  pc_unit #(.C_EXT(1)) u_dut1 (
    .clk(clk), .rst(rst), .stall(stall), .is_compressed(is_compressed),
    .branch_taken(branch_taken), .jalr(jalr), .ImmExt(imm), .RS1(rs1),
    .PC(pc_o[1]), .PCPlus4(plus4_o[1]), .PCTarget(target_o[1]),
    .misalign_exc(exc_o[1]), .bad_addr(bad_o[1]), .redirect_pending(pend_o[1])
  );

  task automatic set_in(input logic s, input logic c, input logic b, input logic j,
                        input logic [31:0] i, input logic [31:0] r);
    stall = s; is_compressed = c; branch_taken = b; jalr = j; imm = i; rs1 = r;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_pend[k] = 32'h0; m_bad[k] = 32'h0; m_pv[k] = 1'b0; m_exc[k] = 1'b0;
    end
  endtask

  // Architectural rules: k==1 models the compressed-capable core.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] step, tgt, applied;
      logic        do_apply;
      step     = m_pc[k] + ((k == 1 && is_compressed) ? 32'd2 : 32'd4);
      tgt      = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (m_pc[k] + imm);
      do_apply = 1'b0;
      applied  = 32'h0;
      m_exc[k] = 1'b0;
      if (stall) begin
        if (jalr || branch_taken) begin
          m_pend[k] = tgt;
          m_pv[k]   = 1'b1;
        end
      end else begin
        if (jalr || branch_taken) begin
          do_apply = 1'b1; applied = tgt;
        end else if (m_pv[k]) begin
          do_apply = 1'b1; applied = m_pend[k];
        end else begin
          m_pc[k] = step;
        end
        m_pv[k] = 1'b0;
        if (do_apply) begin
          if (k == 0 && applied[1]) begin
            m_pc[k] = 32'h100; m_bad[k] = applied; m_exc[k] = 1'b1;
          end else begin
            m_pc[k] = applied;
          end
        end
      end
    end
  endtask

  task automatic drive_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    set_in(0, 0, 0, 1, 32'h0, addr);
    drive_cycle();
    set_in(0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pc_o[k] !== 32'h0 || exc_o[k] !== 1'b0 || bad_o[k] !== 32'h0 || pend_o[k] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset dut%0d: pc=%h exc=%b bad=%h pend=%b expected 0", k,
                 pc_o[k], exc_o[k], bad_o[k], pend_o[k]);
      end
    end
    #3 rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive_cycle();
      checks++;
      if (pc_o[0] !== 32'(4 * i) || plus4_o[0] !== 32'(4 * i + 4) || exc_o[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL seq step %0d: pc=%h plus4=%h exc=%b expected pc=%h", i,
                 pc_o[0], plus4_o[0], exc_o[0], 32'(4 * i));
      end
    end
  endtask

  task automatic test_branch();
    goto_pc(32'h100);
    set_in(0, 0, 1, 0, 32'hFFFF_FFF0, 32'h0);
    #1;
    checks++;
    if (target_o[0] !== 32'hF0) begin
      errors++;
      $display("[TB] FAIL branch PCTarget: got %h expected %h", target_o[0], 32'hF0);
    end
    drive_cycle();
    checks++;
    if (pc_o[0] !== 32'hF0 || pc_o[1] !== 32'hF0) begin
      errors++;
      $display("[TB] FAIL branch apply: got %h/%h expected %h", pc_o[0], pc_o[1], 32'hF0);
    end
    set_in(0, 0, 1, 1, 32'h10, 32'h2001);
    drive_cycle();
    checks++;
    if (pc_o[0] !== 32'h2010 || pc_o[1] !== 32'h2010) begin
      errors++;
      $display("[TB] FAIL jalr wins: got %h/%h expected %h", pc_o[0], pc_o[1], 32'h2010);
    end
  endtask

  task automatic test_stall();
    for (int pass = 0; pass < 2; pass++) begin
      goto_pc(32'h40);
      for (int c = 0; c < 2; c++) begin
        set_in(1, 0, 1, 0, 32'h20, 32'h0);
        drive_cycle();
        checks++;
        if (pc_o[0] !== 32'h40 || pend_o[0] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL stall hold %0d/%0d: pc=%h pend=%b expected pc=%h pend=1", pass, c,
                   pc_o[0], pend_o[0], 32'h40);
        end
      end
      if (pass == 0) set_in(0, 0, 0, 0, 32'h0, 32'h0);
      else           set_in(0, 0, 0, 1, 32'h0, 32'h300);
      drive_cycle();
      checks++;
      if (pc_o[0] !== (pass == 0 ? 32'h60 : 32'h300) || pend_o[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall release %0d: pc=%h pend=%b expected pc=%h pend=0", pass,
                 pc_o[0], pend_o[0], (pass == 0 ? 32'h60 : 32'h300));
      end
    end
  endtask

  task automatic test_trap();
    goto_pc(32'h80);
    set_in(0, 0, 1, 0, 32'h6, 32'h0);
    drive_cycle();
    checks++;
    if (pc_o[0] !== 32'h100 || exc_o[0] !== 1'b1 || bad_o[0] !== 32'h86) begin
      errors++;
      $display("[TB] FAIL trap c0: pc=%h exc=%b bad=%h expected pc=100 exc=1 bad=86",
               pc_o[0], exc_o[0], bad_o[0]);
    end
    checks++;
    if (pc_o[1] !== 32'h86 || exc_o[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no trap c1: pc=%h exc=%b expected pc=86 exc=0", pc_o[1], exc_o[1]);
    end
    set_in(0, 0, 0, 0, 32'h0, 32'h0);
    drive_cycle();
    checks++;
    if (exc_o[0] !== 1'b0 || bad_o[0] !== 32'h86 || pc_o[0] !== 32'h104) begin
      errors++;
      $display("[TB] FAIL trap pulse width: exc=%b bad=%h pc=%h expected exc=0 bad=86 pc=104",
               exc_o[0], bad_o[0], pc_o[0]);
    end
  endtask

  task automatic test_compressed();
    goto_pc(32'h10);
    set_in(0, 1, 0, 0, 32'h0, 32'h0);
    #1;
    checks++;
    if (plus4_o[1] !== 32'h12 || plus4_o[0] !== 32'h14) begin
      errors++;
      $display("[TB] FAIL compressed link: got %h/%h expected 14/12", plus4_o[0], plus4_o[1]);
    end
    drive_cycle();
    checks++;
    if (pc_o[1] !== 32'h12 || pc_o[0] !== 32'h14) begin
      errors++;
      $display("[TB] FAIL compressed step: got %h/%h expected 14/12", pc_o[0], pc_o[1]);
    end
  endtask

  task automatic test_wrap_async_reset();
    goto_pc(32'hFFFF_FFFC);
    drive_cycle();
    checks++;
    if (pc_o[0] !== 32'h0 || pc_o[1] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wrap: got %h/%h expected 0", pc_o[0], pc_o[1]);
    end
    goto_pc(32'h500);
    set_in(1, 0, 1, 0, 32'h40, 32'h0);
    drive_cycle();
    set_in(0, 0, 0, 0, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pc_o[0] !== 32'h0 || pend_o[0] !== 1'b0 || pc_o[1] !== 32'h0 || pend_o[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async reset: pc=%h/%h pend=%b%b expected 0", pc_o[0], pc_o[1],
               pend_o[0], pend_o[1]);
    end
    model_reset();
    #2 rst = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 9) < 3, 1'($urandom), $urandom_range(0, 3) == 0,
             $urandom_range(0, 4) == 0,
             (32'($urandom_range(0, 1023)) - 32'd512) << 1, $urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (plus4_o[k] !== m_pc[k] + ((k == 1 && is_compressed) ? 32'd2 : 32'd4) ||
            target_o[k] !== m_pc[k] + imm) begin
          errors++;
          $display("[TB] FAIL rand comb dut%0d n=%0d: plus4=%h target=%h expected pc=%h imm=%h",
                   k, n, plus4_o[k], target_o[k], m_pc[k], imm);
        end
      end
      drive_cycle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (pc_o[k] !== m_pc[k] || exc_o[k] !== m_exc[k] || bad_o[k] !== m_bad[k] ||
            pend_o[k] !== m_pv[k]) begin
          errors++;
          $display("[TB] FAIL rand state dut%0d n=%0d: pc=%h exc=%b bad=%h pend=%b expected %h %b %h %b",
                   k, n, pc_o[k], exc_o[k], bad_o[k], pend_o[k], m_pc[k], m_exc[k], m_bad[k], m_pv[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_stall();
    test_trap();
    test_compressed();
    test_wrap_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the RISC-V core. Holds the architectural PC register and computes the sequential, branch/JAL and JALR targets.
- Supports stall, a one-entry buffer for redirects that arrive during a stall, optional compressed-instruction (16-bit) stepping, and misaligned-target trapping.
- Sits between the decode/branch logic and the instruction memory address port.

Parameters:
- XLEN, 32, datapath/address width
- RESET_VECTOR, 32'h0000_0000, PC value on reset
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on misaligned-target trap
- C_EXT, 0, 1 = 16-bit instruction alignment and +2 stepping allowed; 0 = 32-bit alignment only

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC; no redirect is applied
- is_compressed  in  1  current instruction is 16-bit; ignored when C_EXT=0
- branch_taken  in  1  redirect to PC+ImmExt (taken branch or JAL)
- jalr  in  1  redirect to (RS1+ImmExt) with bit 0 cleared
- ImmExt  in  XLEN  sign-extended immediate
- RS1  in  XLEN  register source 1 value
- PC  out  XLEN  current PC (registered)
- PCPlus4  out  XLEN  link address: PC+2 if C_EXT and is_compressed, else PC+4 (combinational)
- PCTarget  out  XLEN  PC+ImmExt (combinational)
- misalign_exc  out  1  one-cycle registered pulse on misaligned-target trap
- bad_addr  out  XLEN  faulting target captured on trap (registered, holds until next trap)
- redirect_pending  out  1  pending-redirect buffer is valid

Behaviour:
- Reset (asynchronous, active-high): PC=RESET_VECTOR, misalign_exc=0, bad_addr=0, pending buffer invalid, pend_target=0. Reset mid-stall or with a redirect pending discards everything.
- Arithmetic is modulo 2^XLEN; wrap-around is silent, with no flag.
- Target formation, combinational:
  - seq = PCPlus4
  - br = PC+ImmExt
  - jr = (RS1+ImmExt) & ~1
  - When both jalr and branch_taken are high, jalr wins.
- Live redirect: redir = jalr | branch_taken, with target tgt chosen per the rule above.
- Alignment check: misaligned = tgt[1] when C_EXT=0. When C_EXT=1, tgt[0] is always 0, so misaligned is never raised.
- Update each rising edge, in priority order:
  1. stall=1 and redir=1: PC holds; pend_target<=tgt; pending<=1. A later redirect in a still-stalled cycle overwrites the buffer.
  2. stall=1 and redir=0: PC holds; the buffer holds.
  3. stall=0 and redir=1: apply tgt (the live redirect beats the pending one); pending<=0.
  4. stall=0, redir=0, pending=1: apply pend_target; pending<=0.
  5. Otherwise: PC<=seq.
- Applying a target:
  - If misaligned: PC<=TRAP_VECTOR, bad_addr<=target, misalign_exc<=1.
  - Otherwise: PC<=target.
  - The alignment check runs at application time, not at buffering time.
- misalign_exc is 0 in every cycle that does not apply a misaligned target, so it is exactly one cycle wide per trap.
- The sequential step is never checked for alignment.
- Latency: redirect to new PC is one clock when unstalled. A buffered redirect lands one clock after stall falls.

Decomposition:
- Shared package (core_pkg): XLEN default, RESET_VECTOR, TRAP_VECTOR constants, and a next-PC-select enum {SEL_SEQ, SEL_BR, SEL_JALR, SEL_PEND, SEL_TRAP}.
- One natural sub-module: pc_target_gen. It is purely combinational and produces seq, br, jr, tgt and misaligned. pc_unit holds the PC register, pending buffer and trap registers.

Test Plan:
- Reset and sequential run: assert rst, release, 3 idle cycles -> PC = 0x0, 0x4, 0x8, 0xC; PCPlus4 = PC+4; misalign_exc=0.
- Branch: PC=0x100, ImmExt=0xFFFFFFF0, branch_taken=1 -> PCTarget=0xF0; next PC=0xF0. Then jalr=1 and branch_taken=1, RS1=0x2001, ImmExt=0x10 -> next PC=0x2010 (jalr wins, bit 0 cleared).
- Stall buffering: PC=0x40, stall=1, branch_taken=1, ImmExt=0x20 for 2 cycles -> PC stays 0x40, redirect_pending=1. Drop stall with redir=0 -> PC=0x60 next edge, redirect_pending=0. Repeat with a live jalr (RS1=0x300, ImmExt=0) in the unstall cycle -> PC=0x300 and the buffer is cleared.
- Misaligned trap (C_EXT=0): PC=0x80, branch_taken=1, ImmExt=0x6 -> PC=TRAP_VECTOR 0x100, misalign_exc high for exactly 1 cycle, bad_addr=0x86. Same target with C_EXT=1 -> PC=0x86, no trap.
- Compressed stepping (C_EXT=1): is_compressed=1 at PC=0x10 -> PCPlus4=0x12, next PC=0x12. is_compressed=1 with C_EXT=0 -> step of 4.
- Wrap and async reset: PC=0xFFFFFFFC, idle -> PC=0x0. Assert rst mid-cycle while redirect_pending=1 -> PC=RESET_VECTOR immediately, before the clock edge, and redirect_pending=0.
